// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store path.
// Holds the ldst_ctrl encodings, the memory-access FSM states, the load/store
// opcodes, the ALU operation codes, and helpers that decode a request into
// its alignment check, byte write enables and lane-replicated store data.
package mem_access_unit_pkg;

    // Load/store control as presented by the execute stage.
    typedef enum logic [2:0] {
        LDST_LB  = 3'b000,
        LDST_LH  = 3'b001,
        LDST_LW  = 3'b010,
        LDST_LBU = 3'b011,
        LDST_LHU = 3'b100,
        LDST_SB  = 3'b101,
        LDST_SH  = 3'b110,
        LDST_SW  = 3'b111
    } ldst_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RESP      = 2'd3
    } mau_state_e;

    // Primary opcodes of the load/store instructions.
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    function automatic logic is_store(input logic [2:0] ctrl);
        return (ctrl == LDST_SB) || (ctrl == LDST_SH) || (ctrl == LDST_SW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
        logic r;
        case (ldst_e'(ctrl))
            LDST_LH, LDST_LHU, LDST_SH: r = lo[0];
            LDST_LW, LDST_SW:           r = (lo != 2'b00);
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Big-endian lanes: byte offset 0 is bits [31:24], so we bit 3.
    function automatic logic [3:0] store_we(input logic [2:0] ctrl, input logic [1:0] lo);
        logic [3:0] r;
        case (ldst_e'(ctrl))
            LDST_SB: r = 4'b1000 >> lo;
            LDST_SH: r = lo[1] ? 4'b0011 : 4'b1100;
            LDST_SW: r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Replicate so every enabled lane already carries the right bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] ctrl, input logic [31:0] d);
        logic [31:0] r;
        case (ldst_e'(ctrl))
            LDST_SB: r = {4{d[7:0]}};
            LDST_SH: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   rdata    - word returned by memory
//   addr     - byte offset within the word (addr[1:0])
//   ctrl     - ldst_ctrl of the load
//   ext_data - extracted, extended 32-bit load value
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ctrl,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'b00:   w_byte = rdata[31:24];
            2'b01:   w_byte = rdata[23:16];
            2'b10:   w_byte = rdata[15:8];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        case (ldst_e'(ctrl))
            LDST_LB:  ext_data = {{24{w_byte[7]}}, w_byte};
            LDST_LBU: ext_data = {24'd0, w_byte};
            LDST_LH:  ext_data = {{16{w_half[15]}}, w_half};
            LDST_LHU: ext_data = {16'd0, w_half};
            default:  ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a single-port memory.
// Accepts one request at a time, flags misaligned accesses, issues a word
// request with byte enables, and returns extended load data to writeback.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   req_valid/req_ready, ldst_ctrl,
//   addr, store_data, dest_reg        - request from execute
//   mem_req/mem_gnt, mem_addr, mem_we,
//   mem_wdata, mem_rvalid, mem_rdata  - memory port
//   rsp_valid, rsp_data, rsp_reg      - load response (one-cycle pulse)
//   store_done                        - store granted (one-cycle pulse)
//   exc_valid, exc_addr               - misaligned access exception
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  ldst_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_reg,
    output logic        store_done,
    output logic        exc_valid,
    output logic [31:0] exc_addr
);

    mau_state_e  r_state;
    logic [2:0]  r_ctrl;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_dest;
    logic        r_req_ready;
    logic        r_mem_req;
    logic [29:0] r_mem_addr;
    logic [3:0]  r_mem_we;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_reg;
    logic        r_store_done;
    logic        r_exc_valid;
    logic [31:0] r_exc_addr;
    logic [31:0] w_ext;

    load_extract u_extract (
        .rdata    (mem_rdata),
        .addr     (r_addr_lo),
        .ctrl     (r_ctrl),
        .ext_data (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ctrl       <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_dest       <= 5'd0;
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 30'd0;
            r_mem_we     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
            r_rsp_reg    <= 5'd0;
            r_store_done <= 1'b0;
            r_exc_valid  <= 1'b0;
            r_exc_addr   <= 32'd0;
        end else begin
            // Pulse outputs default low; set only in their one cycle.
            r_rsp_valid  <= 1'b0;
            r_store_done <= 1'b0;
            r_exc_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(ldst_ctrl, addr[1:0])) begin
                            // Rejected in place: stay in IDLE, still ready.
                            r_exc_valid <= 1'b1;
                            r_exc_addr  <= addr;
                        end else begin
                            r_ctrl      <= ldst_ctrl;
                            r_addr_lo   <= addr[1:0];
                            r_dest      <= dest_reg;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= addr[31:2];
                            r_mem_we    <= store_we(ldst_ctrl, addr[1:0]);
                            r_mem_wdata <= store_wdata(ldst_ctrl, store_data);
                            r_req_ready <= 1'b0;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Request fields are registers, so they hold until gnt.
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 4'd0;
                        if (is_store(r_ctrl)) begin
                            r_store_done <= 1'b1;
                            r_req_ready  <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (mem_rvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_ext;
                        r_rsp_reg   <= r_dest;
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    // RESP: rsp_valid is high for exactly this cycle.
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_reg    = r_rsp_reg;
    assign store_done = r_store_done;
    assign exc_valid  = r_exc_valid;
    assign exc_addr   = r_exc_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a behavioural
// reference model of the load/store rules.
module tb_mem_access_unit;

    localparam logic [2:0] C_LB = 3'd0, C_LH = 3'd1, C_LW = 3'd2, C_LBU = 3'd3,
                           C_LHU = 3'd4, C_SB = 3'd5, C_SH = 3'd6, C_SW = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  ldst_ctrl;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        mem_req;
    logic        mem_gnt;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_reg;
    logic        store_done;
    logic        exc_valid;
    logic [31:0] exc_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .ldst_ctrl(ldst_ctrl), .addr(addr), .store_data(store_data), .dest_reg(dest_reg),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_reg(rsp_reg),
        .store_done(store_done), .exc_valid(exc_valid), .exc_addr(exc_addr)
    );

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] c);
        if (c == C_LW || c == C_SW) return 4;
        if (c == C_LH || c == C_LHU || c == C_SH) return 2;
        return 1;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] c, input logic [31:0] a);
        return (a % ref_size(c)) != 0;
    endfunction

    function automatic bit ref_is_store(input logic [2:0] c);
        return c >= C_SB;
    endfunction

    // Byte offset k (big-endian) lives at bits 8*(3-k).
    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned off, v;
        off = a % 4;
        if (ref_size(c) == 1) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (c == C_LB && v >= 128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (ref_size(c) == 2) begin
            v = (rd >> (8 * (2 - off))) & 32'hFFFF;
            if (c == C_LH && v >= 32768) v = v + 32'hFFFF0000;
            return v;
        end
        return rd;
    endfunction

    function automatic logic [3:0] ref_we(input logic [2:0] c, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (!ref_is_store(c)) return 4'b0000;
        if (c == C_SW) return 4'b1111;
        if (c == C_SH) return (off == 0) ? 4'b1100 : 4'b0011;
        return 4'(8 >> off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] d);
        if (c == C_SB) return (d % 256) * 32'h01010101;
        if (c == C_SH) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] r);
        req_valid  = 1'b1;
        ldst_ctrl  = c;
        addr       = a;
        store_data = d;
        dest_reg   = r;
    endtask

    // Load with gnt after gd extra cycles and rvalid after rvd extra cycles.
    task automatic do_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rd,
                           input logic [4:0] r, input int gd, input int rvd);
        chk("ld_ready", 32'(req_ready), 32'd1);
        present(c, a, $urandom, r);
        tick();
        req_valid = 1'b0;
        addr      = $urandom;
        for (int i = 0; i <= gd; i++) begin
            chk("ld_mem_req", 32'(mem_req), 32'd1);
            chk("ld_mem_addr", 32'(mem_addr), 32'(a[31:2]));
            chk("ld_mem_we", 32'(mem_we), 32'd0);
            chk("ld_busy", 32'(req_ready), 32'd0);
            mem_rvalid = 1'b1;           // ignored outside WAIT_DATA
            mem_rdata  = ~rd;
            mem_gnt    = (i == gd);
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        for (int i = 0; i < rvd; i++) begin
            chk("ld_wait_no_rsp", 32'(rsp_valid), 32'd0);
            mem_gnt = 1'b1;              // ignored outside REQ
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ld_rsp_data", rsp_data, ref_load(c, a, rd));
        chk("ld_rsp_reg", 32'(rsp_reg), 32'(r));
        tick();
        chk("ld_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("ld_ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic do_store(input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] d, input int gd);
        present(c, a, d, 5'($urandom));
        tick();
        req_valid  = 1'b0;
        store_data = $urandom;
        for (int i = 0; i <= gd; i++) begin
            chk("st_mem_req", 32'(mem_req), 32'd1);
            chk("st_mem_addr", 32'(mem_addr), 32'(a[31:2]));
            chk("st_mem_we", 32'(mem_we), 32'(ref_we(c, a)));
            chk("st_mem_wdata", mem_wdata, ref_wdata(c, d));
            chk("st_done_early", 32'(store_done), 32'd0);
            mem_gnt = (i == gd);
            tick();
        end
        mem_gnt = 1'b0;
        chk("st_done", 32'(store_done), 32'd1);
        chk("st_req_drop", 32'(mem_req), 32'd0);
        tick();
        chk("st_done_pulse", 32'(store_done), 32'd0);
        chk("st_ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic do_misaligned(input logic [2:0] c, input logic [31:0] a);
        present(c, a, $urandom, 5'($urandom));
        tick();
        req_valid = 1'b0;
        chk("exc_valid", 32'(exc_valid), 32'd1);
        chk("exc_addr", exc_addr, a);
        chk("exc_no_req", 32'(mem_req), 32'd0);
        chk("exc_ready", 32'(req_ready), 32'd1);
        tick();
        chk("exc_pulse", 32'(exc_valid), 32'd0);
        chk("exc_addr_hold", exc_addr, a);
        chk("exc_no_req2", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; ldst_ctrl = 3'd0; addr = 32'd0;
        store_data = 32'd0; dest_reg = 5'd0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp", {rsp_data[30:0], rsp_valid}, 32'd0);
        chk("rst_rsp_reg", 32'(rsp_reg), 32'd0);
        chk("rst_pulses", 32'({store_done, exc_valid}), 32'd0);
        chk("rst_exc_addr", exc_addr, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Directed scenarios
        do_load(C_LB, 32'h1001, 32'h12F45678, 5'd3, 0, 0);
        chk("lb_value", ref_load(C_LB, 32'h1001, 32'h12F45678), 32'hFFFFFFF4);
        do_load(C_LHU, 32'h2002, 32'hAAAA8001, 5'd4, 0, 0);
        do_load(C_LH, 32'h2002, 32'hAAAA8001, 5'd4, 1, 2);
        do_store(C_SB, 32'h3003, 32'h000000A5, 4);
        do_misaligned(C_SW, 32'h4002);

        // Reset in WAIT_DATA abandons the load.
        present(C_LW, 32'h5000, 32'd0, 5'd11);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_data", rsp_data, 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        tick();
        chk("arst_no_rsp2", 32'(rsp_valid), 32'd0);
        do_load(C_LW, 32'h5004, 32'h01234567, 5'd12, 0, 0);

        // Back-to-back with req_valid held high.
        present(C_LH, 32'h6002, 32'd0, 5'd7);
        tick();
        present(C_LBU, 32'h7003, 32'd0, 5'd9);
        chk("b2b_a_addr", 32'(mem_addr), 32'h6000 >> 2);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234F00D;
        chk("b2b_busy", 32'(req_ready), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("b2b_a_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b_a_data", rsp_data, ref_load(C_LH, 32'h6002, 32'h1234F00D));
        chk("b2b_a_reg", 32'(rsp_reg), 32'd7);
        chk("b2b_busy_resp", 32'(req_ready), 32'd0);
        tick();
        chk("b2b_ready", 32'(req_ready), 32'd1);
        chk("b2b_no_req_yet", 32'(mem_req), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("b2b_b_req", 32'(mem_req), 32'd1);
        chk("b2b_b_addr", 32'(mem_addr), 32'h7000 >> 2);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEBABE;
        tick();
        mem_rvalid = 1'b0;
        chk("b2b_b_rsp", 32'(rsp_valid), 32'd1);
        chk("b2b_b_data", rsp_data, 32'h000000BE);
        chk("b2b_b_reg", 32'(rsp_reg), 32'd9);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  c;
            logic [31:0] a;
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            if (ref_misaligned(c, a))        do_misaligned(c, a);
            else if (ref_is_store(c))        do_store(c, a, $urandom, $urandom_range(0, 3));
            else do_load(c, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
